// File: rtl/data_mem_responder_pkg.sv
// Shared bus width, MMIO offset map and TCTRL bit positions for data_mem_responder.
`default_nettype none

package data_mem_responder_pkg;

    localparam int REG_BUS = 32;

    localparam logic [7:0] OFF_TCOUNT = 8'h00;
    localparam logic [7:0] OFF_TCMP   = 8'h04;
    localparam logic [7:0] OFF_TCTRL  = 8'h08;
    localparam logic [7:0] OFF_GPOUT  = 8'h0C;
    localparam logic [7:0] OFF_GPIN   = 8'h10;

    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_AR   = 1;
    localparam int TCTRL_PEND = 2;

    // sel[n] enables byte bits [8n+7:8n]; sel[3] is the big-endian byte 0.
    function automatic logic [REG_BUS-1:0] lane_merge(
        input logic [REG_BUS-1:0] old_val,
        input logic [REG_BUS-1:0] new_val,
        input logic [3:0]         sel
    );
        logic [REG_BUS-1:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_mmio_timer.sv
// Timer block: TCOUNT/TCMP/TCTRL registers, compare-match logic and the PEND flag.
`default_nettype none

module data_mem_responder_mmio_timer
    import data_mem_responder_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr,
    input  logic [7:0]         offset,
    input  logic [3:0]         sel,
    input  logic [REG_BUS-1:0] wdata,
    output logic [REG_BUS-1:0] tcount,
    output logic [REG_BUS-1:0] tcmp,
    output logic [REG_BUS-1:0] tctrl,
    output logic               irq
);

    logic               en;
    logic               autoreload;
    logic               pend;
    logic               match;
    logic [REG_BUS-1:0] cnt_next;
    logic               wr_tcount;
    logic               wr_tcmp;
    logic               wr_tctrl;

    always_comb begin
        match     = en && (tcount == tcmp);
        cnt_next  = tcount;
        if (en) cnt_next = (match && autoreload) ? '0 : tcount + 1'b1;
        wr_tcount = wr && (offset == OFF_TCOUNT);
        wr_tcmp   = wr && (offset == OFF_TCMP);
        // Control bits all live in the lowest byte lane.
        wr_tctrl  = wr && (offset == OFF_TCTRL) && sel[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcount     <= '0;
            tcmp       <= '1;
            en         <= 1'b0;
            autoreload <= 1'b0;
            pend       <= 1'b0;
        end else begin
            // CPU lanes override the counted value; the match used pre-write state.
            tcount <= wr_tcount ? lane_merge(cnt_next, wdata, sel) : cnt_next;
            if (wr_tcmp) tcmp <= lane_merge(tcmp, wdata, sel);
            if (wr_tctrl) begin
                en         <= wdata[TCTRL_EN];
                autoreload <= wdata[TCTRL_AR];
            end
            if (match) pend <= 1'b1;
            else if (wr_tctrl && wdata[TCTRL_PEND]) pend <= 1'b0;
        end
    end

    assign tctrl = {{(REG_BUS-3){1'b0}}, pend, autoreload, en};
    assign irq   = pend;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: word RAM plus MMIO timer/GPIO, combinational reads.
`default_nettype none

module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int         RAM_WORDS = 1024,
    parameter int         GPIO_W    = 16,
    parameter logic [3:0] IO_PAGE   = 4'h1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce_i,
    input  logic               we_i,
    input  logic [31:0]        addr_i,
    input  logic [3:0]         sel_i,
    input  logic [REG_BUS-1:0] wdata_i,
    output logic [REG_BUS-1:0] rdata_o,
    input  logic [GPIO_W-1:0]  gpio_i,
    output logic [GPIO_W-1:0]  gpio_o,
    output logic               timer_irq_o
);

    localparam int IDX_W = $clog2(RAM_WORDS);

    logic [REG_BUS-1:0] mem [0:RAM_WORDS-1];

    logic               is_io;
    logic [IDX_W-1:0]   ram_idx;
    logic [7:0]         offset;
    logic               wr_ram;
    logic               wr_io;
    logic               rd;
    logic [GPIO_W-1:0]  gpout;
    logic [GPIO_W-1:0]  sync1;
    logic [GPIO_W-1:0]  sync2;
    logic [REG_BUS-1:0] gpout_wide;
    logic [REG_BUS-1:0] gpout_merged;
    logic [REG_BUS-1:0] io_rdata;
    logic [REG_BUS-1:0] tcount;
    logic [REG_BUS-1:0] tcmp;
    logic [REG_BUS-1:0] tctrl;
    logic               unused_bits;

    always_comb begin
        is_io        = (addr_i[31:28] == IO_PAGE);
        ram_idx      = addr_i[IDX_W+1:2];
        offset       = addr_i[7:0];
        wr_ram       = ce_i && we_i && !is_io;
        wr_io        = ce_i && we_i && is_io;
        rd           = ce_i && !we_i;
        gpout_wide   = '0;
        gpout_wide[GPIO_W-1:0] = gpout;
        gpout_merged = lane_merge(gpout_wide, wdata_i, sel_i);
    end

    assign unused_bits = ^{addr_i, gpout_merged};

    data_mem_responder_mmio_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .wr     (wr_io),
        .offset (offset),
        .sel    (sel_i),
        .wdata  (wdata_i),
        .tcount (tcount),
        .tcmp   (tcmp),
        .tctrl  (tctrl),
        .irq    (timer_irq_o)
    );

    // RAM contents are intentionally not reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && wr_ram) mem[ram_idx] <= lane_merge(mem[ram_idx], wdata_i, sel_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpout <= '0;
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpio_i;
            sync2 <= sync1;
            if (wr_io && offset == OFF_GPOUT) gpout <= gpout_merged[GPIO_W-1:0];
        end
    end

    always_comb begin
        io_rdata = '0;
        case (offset)
            OFF_TCOUNT: io_rdata = tcount;
            OFF_TCMP:   io_rdata = tcmp;
            OFF_TCTRL:  io_rdata = tctrl;
            OFF_GPOUT:  io_rdata[GPIO_W-1:0] = gpout;
            OFF_GPIN:   io_rdata[GPIO_W-1:0] = sync2;
            default:    io_rdata = '0;
        endcase
        rdata_o = '0;
        if (rd) rdata_o = is_io ? io_rdata : mem[ram_idx];
    end

    assign gpio_o = gpout;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: vector table plus timer/GPIO/reset sequences.
`default_nettype none

module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic [15:0] gpio_i;
    logic [15:0] gpio_o;
    logic        timer_irq_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    data_mem_responder #(.RAM_WORDS(1024), .GPIO_W(16), .IO_PAGE(4'h1)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .sel_i       (sel_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .gpio_i      (gpio_i),
        .gpio_o      (gpio_o),
        .timer_irq_o (timer_irq_o)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ce, input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] wdata);
        ce_i = ce; we_i = we; addr_i = addr; sel_i = sel; wdata_i = wdata;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Write and wait for the committing edge.
    task automatic wr(input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] wdata);
        drive(1'b1, 1'b1, addr, sel, wdata);
        step();
        idle();
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        drive(1'b1, 1'b0, addr, 4'hF, 32'h0);
        #1;
        check32(name, rdata_o, exp);
        idle();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h1000_0000, 4'hF, 32'h0,          1'b1, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h1000_0004, 4'hF, 32'h0,          1'b1, 32'hFFFF_FFFF};
        vecs[2]  = '{1'b1, 1'b0, 32'h1000_0008, 4'hF, 32'h0,          1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'hAABB_CCDD,  1'b1, 32'h0000_0000};
        vecs[4]  = '{1'b1, 1'b1, 32'h0000_0010, 4'h2, 32'h0000_1100,  1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0,          1'b1, 32'hAABB_11DD};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF,  1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0012, 4'h1, 32'h0,          1'b1, 32'hAABB_11DD};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_1000, 4'hF, 32'h1234_5678,  1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0,          1'b1, 32'h1234_5678};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 4'hF, 32'h0,          1'b1, 32'h0000_0000};
        vecs[11] = '{1'b1, 1'b1, 32'h1000_000C, 4'hF, 32'hFFFF_1234,  1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 32'h1000_000C, 4'hF, 32'h0,          1'b1, 32'h0000_1234};
        vecs[13] = '{1'b1, 1'b1, 32'h1000_0010, 4'hF, 32'hFFFF_FFFF,  1'b0, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 32'h1000_0040, 4'hF, 32'h0,          1'b1, 32'h0000_0000};
        vecs[15] = '{1'b1, 1'b0, 32'h2000_0010, 4'hF, 32'h0,          1'b1, 32'hAABB_11DD};
        vecs[16] = '{1'b1, 1'b1, 32'h1000_0008, 4'hF, 32'hFFFF_FFF8,  1'b0, 32'h0};
        vecs[17] = '{1'b1, 1'b1, 32'h1000_0004, 4'h8, 32'h1200_0000,  1'b0, 32'h0};
        vecs[18] = '{1'b1, 1'b0, 32'h1000_0004, 4'hF, 32'h0,          1'b1, 32'h12FF_FFFF};

        rst = 1'b1;
        gpio_i = 16'h0;
        idle();
        step();
        step();
        check32("irq_reset", {31'b0, timer_irq_o}, 32'h0);
        check32("gpio_o_reset", {16'b0, gpio_o}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata);
            #1;
            if (vecs[i].chk) check32($sformatf("vec%0d", i), rdata_o, vecs[i].exp);
            step();
        end
        idle();
        check32("gpio_o_after_write", {16'b0, gpio_o}, 32'h0000_1234);
        rd_check("tctrl_upper_zero", 32'h1000_0008, 32'h0);

        // GPIN through the 2-flop synchroniser
        gpio_i = 16'h00A5;
        rd_check("gpin_c0", 32'h1000_0010, 32'h0);
        step();
        rd_check("gpin_c1", 32'h1000_0010, 32'h0);
        step();
        rd_check("gpin_c2", 32'h1000_0010, 32'h0000_00A5);

        // Auto-reload: PEND exactly 4 cycles after EN is written
        wr(32'h1000_0004, 4'hF, 32'h3);
        wr(32'h1000_0008, 4'hF, 32'h3);
        for (int k = 1; k <= 4; k++) begin
            check32($sformatf("irq_ar_k%0d", k - 1), {31'b0, timer_irq_o}, 32'h0);
            step();
        end
        check32("irq_ar_fire", {31'b0, timer_irq_o}, 32'h1);
        rd_check("tcount_reload", 32'h1000_0000, 32'h0);

        // W1C race: clear first (count 0), then let count reach 3
        wr(32'h1000_0008, 4'hF, 32'h7);
        check32("irq_cleared", {31'b0, timer_irq_o}, 32'h0);
        step();
        step();
        rd_check("tcount_at_match", 32'h1000_0000, 32'h3);
        wr(32'h1000_0008, 4'hF, 32'h7);
        check32("irq_set_wins", {31'b0, timer_irq_o}, 32'h1);
        rd_check("tctrl_pend", 32'h1000_0008, 32'h7);
        wr(32'h1000_0008, 4'hF, 32'h7);
        check32("irq_w1c", {31'b0, timer_irq_o}, 32'h0);

        // Count is 1 here; lane-3 CPU write merges with counted value 2
        wr(32'h1000_0000, 4'h8, 32'hAB00_0000);
        rd_check("tcount_lane_win", 32'h1000_0000, 32'hAB00_0002);

        // Re-arm a match, then reset mid-run with an aborted RAM write
        wr(32'h1000_0000, 4'hF, 32'h0);
        for (int k = 0; k < 4; k++) step();
        check32("irq_before_rst", {31'b0, timer_irq_o}, 32'h1);
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'h0);
        step();
        rst = 1'b0;
        idle();
        check32("irq_after_rst", {31'b0, timer_irq_o}, 32'h0);
        check32("gpio_o_after_rst", {16'b0, gpio_o}, 32'h0);
        rd_check("tcount_after_rst", 32'h1000_0000, 32'h0);
        rd_check("tcmp_after_rst", 32'h1000_0004, 32'hFFFF_FFFF);
        rd_check("ram_kept", 32'h0000_0010, 32'hAABB_11DD);
        step();
        rd_check("tcount_held", 32'h1000_0000, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
